// File: rtl/v_counter.sv
// Vertical timing stage: line counter, V_SYNC, END_FRAME, VIDEO_ON and region FSM.
// Optional frame counter enabled by defining VCNT_FRAME_COUNT_EN.
module v_counter #(
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC_LEN = 2,
  parameter int V_BACK     = 33,
  parameter int H_VISIBLE  = 640,
  parameter int FRAME_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_end_line,
  input  logic [31:0]        i_current_pixel,
  output logic [9:0]         o_current_line,
  output logic               o_v_sync,
  output logic               o_end_frame,
  output logic               o_video_on,
  output logic [1:0]         o_v_state
`ifdef VCNT_FRAME_COUNT_EN
  ,
  output logic [FRAME_W-1:0] o_frame_count
`endif
);

  typedef enum logic [1:0] {
    S_ACTIVE = 2'd0,
    S_FRONT  = 2'd1,
    S_SYNC   = 2'd2,
    S_BACK   = 2'd3
  } state_t;

  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC_LEN + V_BACK;
  localparam logic [9:0]  L_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  L_FRONT  = 10'(V_VISIBLE);
  localparam logic [9:0]  L_SYNC   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  L_BACK   = 10'(V_VISIBLE + V_FRONT + V_SYNC_LEN);
  localparam logic [31:0] L_H_VIS  = 32'(H_VISIBLE);

  logic [9:0] r_line;
  state_t     r_state;
  logic       r_v_sync;
  logic       r_end_frame;

  logic [9:0] w_line_next;
  state_t     w_state_next;
  logic       w_v_sync_next;
  logic       w_wrap;

  // Region is decoded from the line being entered, so zero-length porch or
  // sync regions are skipped naturally at the same line.
  always_comb begin
    w_wrap        = i_end_line && (r_line == L_LAST);
    w_line_next   = r_line;
    w_state_next  = r_state;
    w_v_sync_next = r_v_sync;
    if (i_end_line) begin
      w_line_next = w_wrap ? 10'd0 : r_line + 10'd1;
      if (w_line_next < L_FRONT) begin
        w_state_next = S_ACTIVE;
      end else if (w_line_next < L_SYNC) begin
        w_state_next = S_FRONT;
      end else if (w_line_next < L_BACK) begin
        w_state_next = S_SYNC;
      end else begin
        w_state_next = S_BACK;
      end
      w_v_sync_next = (w_state_next != S_SYNC);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_line      <= 10'd0;
      r_state     <= S_ACTIVE;
      r_v_sync    <= 1'b1;
      r_end_frame <= 1'b0;
    end else begin
      r_line      <= w_line_next;
      r_state     <= w_state_next;
      r_v_sync    <= w_v_sync_next;
      r_end_frame <= w_wrap;
    end
  end

`ifdef VCNT_FRAME_COUNT_EN
  logic [FRAME_W-1:0] r_frame_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_count <= '0;
    end else if (w_wrap) begin
      r_frame_count <= r_frame_count + 1'b1;
    end
  end

  assign o_frame_count = r_frame_count;
`endif

  assign o_current_line = r_line;
  assign o_v_sync       = r_v_sync;
  assign o_end_frame    = r_end_frame;
  assign o_v_state      = r_state;
  assign o_video_on     = (r_state == S_ACTIVE) && (i_current_pixel < L_H_VIS);

endmodule

// File: tb/tb_v_counter.sv
// Directed self-checking bench for v_counter; define VCNT_FRAME_COUNT_EN to also cover the frame counter.
module tb_v_counter;

`ifdef VCNT_FRAME_COUNT_EN
  localparam int FW = 2;
`else
  localparam int FW = 16;
`endif

  logic        clk;
  logic        reset;
  logic        end_line;
  logic [31:0] current_pixel;
  logic [9:0]  current_line;
  logic        v_sync;
  logic        end_frame;
  logic        video_on;
  logic [1:0]  v_state;
`ifdef VCNT_FRAME_COUNT_EN
  logic [FW-1:0] frame_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  v_counter #(.FRAME_W(FW)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_end_line      (end_line),
    .i_current_pixel (current_pixel),
    .o_current_line  (current_line),
    .o_v_sync        (v_sync),
    .o_end_frame     (end_frame),
    .o_video_on      (video_on),
    .o_v_state       (v_state)
`ifdef VCNT_FRAME_COUNT_EN
    ,
    .o_frame_count   (frame_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge with the current inputs; outputs are stable #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      end_line = 1'b1;
      tick();
    end
    end_line = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    end_line = 1'b0;
    current_pixel = 32'd0;
    tick();

    for (int i = 0; i < 3; i++) begin
      end_line = (i % 2 == 0);
      tick();
      check("rst_line",  32'(current_line), 32'd0);
      check("rst_vsync", 32'(v_sync),       32'd1);
      check("rst_state", 32'(v_state),      32'd0);
      check("rst_eof",   32'(end_frame),    32'd0);
    end
`ifdef VCNT_FRAME_COUNT_EN
    check("rst_fc", 32'(frame_count), 32'd0);
`endif
    end_line = 1'b0;
    reset = 1'b0;
    tick();
    check("idle_line", 32'(current_line), 32'd0);
    current_pixel = 32'd639;
    #1;
    check("vid_l0_p639", 32'(video_on), 32'd1);

    pulses(479);
    check("line479", 32'(current_line), 32'd479);
    check("vid_l479_p639", 32'(video_on), 32'd1);
    current_pixel = 32'd640;
    #1;
    check("vid_l479_p640", 32'(video_on), 32'd0);
    current_pixel = 32'd0;
    tick();
    check("hold_line", 32'(current_line), 32'd479);

    pulses(1);
    check("line480", 32'(current_line), 32'd480);
    check("st_front", 32'(v_state), 32'd1);
    check("vid_l480_p0", 32'(video_on), 32'd0);
    check("vsync480", 32'(v_sync), 32'd1);

    pulses(9);
    check("line489_vsync", 32'(v_sync), 32'd1);
    pulses(1);
    check("line490", 32'(current_line), 32'd490);
    check("vsync490", 32'(v_sync), 32'd0);
    check("st_sync", 32'(v_state), 32'd2);
    pulses(1);
    check("vsync491", 32'(v_sync), 32'd0);
    pulses(1);
    check("vsync492", 32'(v_sync), 32'd1);
    check("st_back", 32'(v_state), 32'd3);

    pulses(32);
    check("line524", 32'(current_line), 32'd524);
    check("eof_before", 32'(end_frame), 32'd0);
    pulses(1);
    check("wrap_line", 32'(current_line), 32'd0);
    check("wrap_eof",  32'(end_frame),    32'd1);
    check("wrap_state", 32'(v_state),     32'd0);
    check("wrap_vsync", 32'(v_sync),      32'd1);
`ifdef VCNT_FRAME_COUNT_EN
    check("wrap_fc", 32'(frame_count), 32'd1);
`endif
    tick();
    check("eof_one_cycle", 32'(end_frame), 32'd0);

    // END_LINE held high across three cycles counts three lines.
    pulses(3);
    check("held_high", 32'(current_line), 32'd3);

    pulses(297);
    check("line300", 32'(current_line), 32'd300);
    reset = 1'b1;
    end_line = 1'b1;
    tick();
    reset = 1'b0;
    end_line = 1'b0;
    check("midrst_line", 32'(current_line), 32'd0);
    check("midrst_eof",  32'(end_frame),    32'd0);
    check("midrst_state", 32'(v_state),     32'd0);
    pulses(1);
    check("resume_line", 32'(current_line), 32'd1);

`ifdef VCNT_FRAME_COUNT_EN
    check("midrst_fc", 32'(frame_count), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int f = 0; f < 4; f++) begin
      pulses(525);
      check("fc_eof", 32'(end_frame), 32'd1);
      check("fc_seq", 32'(frame_count), 32'((f + 1) % 4));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
